vga_timing: RTL and testbench

Generates the VGA raster: horizontal and vertical pixel counters plus sync and blanking strobes for 800x600@60 Hz at a 40 MHz pixel clock. It is the first stage of the video pipeline and feeds draw_bg's `vcount_in/vsync_in/vblnk_in/hcount_in/hsync_in/hblnk_in` directly. It also emits a one-cycle frame-start strobe for game-logic pacing.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_timing.sv | 103 ++++++++++
 tb/tb_vga_timing.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : shared 800x600@60 Hz (40 MHz) raster timing constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int COUNT_W        = 11;

  localparam int HOR_PIXELS     = 800;
  localparam int HOR_TOTAL      = 1056;
  localparam int HOR_SYNC_START = 840;
  localparam int HOR_SYNC_TIME  = 128;

  localparam int VER_PIXELS     = 600;
  localparam int VER_TOTAL      = 628;
  localparam int VER_SYNC_START = 601;
  localparam int VER_SYNC_TIME  = 4;

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// vga_timing : raster counters with aligned, registered sync/blank strobes
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_timing
  import vga_pkg::COUNT_W;
#(
  parameter int HOR_PIXELS     = vga_pkg::HOR_PIXELS,
  parameter int HOR_TOTAL      = vga_pkg::HOR_TOTAL,
  parameter int HOR_SYNC_START = vga_pkg::HOR_SYNC_START,
  parameter int HOR_SYNC_TIME  = vga_pkg::HOR_SYNC_TIME,
  parameter int VER_PIXELS     = vga_pkg::VER_PIXELS,
  parameter int VER_TOTAL      = vga_pkg::VER_TOTAL,
  parameter int VER_SYNC_START = vga_pkg::VER_SYNC_START,
  parameter int VER_SYNC_TIME  = vga_pkg::VER_SYNC_TIME
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COUNT_W-1:0] hcount,
  output logic               hsync,
  output logic               hblnk,
  output logic [COUNT_W-1:0] vcount,
  output logic               vsync,
  output logic               vblnk,
  output logic               frame_start
);

  localparam logic [COUNT_W-1:0] C_H_LAST  = COUNT_W'(HOR_TOTAL - 1);
  localparam logic [COUNT_W-1:0] C_H_PIX   = COUNT_W'(HOR_PIXELS);
  localparam logic [COUNT_W-1:0] C_H_SS    = COUNT_W'(HOR_SYNC_START);
  localparam logic [COUNT_W-1:0] C_H_SE    = COUNT_W'(HOR_SYNC_START + HOR_SYNC_TIME - 1);
  localparam logic [COUNT_W-1:0] C_V_LAST  = COUNT_W'(VER_TOTAL - 1);
  localparam logic [COUNT_W-1:0] C_V_PIX   = COUNT_W'(VER_PIXELS);
  localparam logic [COUNT_W-1:0] C_V_SS    = COUNT_W'(VER_SYNC_START);
  localparam logic [COUNT_W-1:0] C_V_SE    = COUNT_W'(VER_SYNC_START + VER_SYNC_TIME - 1);

  if (HOR_TOTAL > 2047 || VER_TOTAL > 2047 ||
      HOR_SYNC_START + HOR_SYNC_TIME > HOR_TOTAL ||
      VER_SYNC_START + VER_SYNC_TIME > VER_TOTAL ||
      HOR_PIXELS > HOR_TOTAL || VER_PIXELS > VER_TOTAL) begin : g_param_check
    $error("vga_timing: timing parameters exceed 11-bit range or total");
  end

  logic [COUNT_W-1:0] w_h_nxt;
  logic [COUNT_W-1:0] w_v_nxt;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_fs_nxt;

  always_comb begin
    w_h_wrap = (hcount == C_H_LAST);
    w_v_wrap = (vcount == C_V_LAST);
    w_h_nxt  = hcount;
    w_v_nxt  = vcount;
    w_fs_nxt = 1'b0;
    if (en) begin
      w_h_nxt = w_h_wrap ? '0 : hcount + 1'b1;
      if (w_h_wrap) begin
        w_v_nxt = w_v_wrap ? '0 : vcount + 1'b1;
      end
      w_fs_nxt = w_h_wrap && w_v_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount <= '0;
    end else begin
      hcount <= w_h_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vcount <= '0;
    end else begin
      vcount <= w_v_nxt;
    end
  end

  // Strobes decode the next counter values so they land with the counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hblnk       <= (w_h_nxt >= C_H_PIX) && (w_h_nxt <= C_H_LAST);
      hsync       <= (w_h_nxt >= C_H_SS) && (w_h_nxt <= C_H_SE);
      vblnk       <= (w_v_nxt >= C_V_PIX) && (w_v_nxt <= C_V_LAST);
      vsync       <= (w_v_nxt >= C_V_SS) && (w_v_nxt <= C_V_SE);
      frame_start <= w_fs_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ============================================================================
// tb_vga_timing : directed checks of default and reduced-size raster timing
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing;

  logic        clk;
  logic        rst;
  logic        en_a;
  logic        en_b;

  logic [10:0] hcount, vcount;
  logic        hsync, hblnk, vsync, vblnk, frame_start;

  logic [10:0] s_hcount, s_vcount;
  logic        s_hsync, s_hblnk, s_vsync, s_vblnk, s_frame_start;

  int checks = 0;
  int errors = 0;

  vga_timing dut (
    .clk(clk), .rst(rst), .en(en_a),
    .hcount(hcount), .hsync(hsync), .hblnk(hblnk),
    .vcount(vcount), .vsync(vsync), .vblnk(vblnk),
    .frame_start(frame_start)
  );

  // Small raster: 12 x 7, hsync h=9..10, hblnk h>=8, vsync v=5, vblnk v>=4.
  vga_timing #(
    .HOR_PIXELS(8), .HOR_TOTAL(12), .HOR_SYNC_START(9), .HOR_SYNC_TIME(2),
    .VER_PIXELS(4), .VER_TOTAL(7),  .VER_SYNC_START(5), .VER_SYNC_TIME(1)
  ) sml (
    .clk(clk), .rst(rst), .en(en_b),
    .hcount(s_hcount), .hsync(s_hsync), .hblnk(s_hblnk),
    .vcount(s_vcount), .vsync(s_vsync), .vblnk(s_vblnk),
    .frame_start(s_frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hcount"}, 32'(hcount), 0);
    chk({tag, "_vcount"}, 32'(vcount), 0);
    chk({tag, "_hsync"},  32'(hsync), 0);
    chk({tag, "_hblnk"},  32'(hblnk), 0);
    chk({tag, "_vsync"},  32'(vsync), 0);
    chk({tag, "_vblnk"},  32'(vblnk), 0);
    chk({tag, "_fs"},     32'(frame_start), 0);
    chk({tag, "_s_hcount"}, 32'(s_hcount), 0);
    chk({tag, "_s_vcount"}, 32'(s_vcount), 0);
    chk({tag, "_s_fs"},     32'(s_frame_start), 0);
  endtask

  initial begin
    int hs_cnt;
    int hb_cnt;
    int fs_cnt;
    int h;
    int v;

    rst  = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");

    // Release reset; first edge must take hcount 0 -> 1.
    rst  = 1'b1;
    en_a = 1'b1;
    hs_cnt = 0;
    hb_cnt = 0;
    for (int i = 1; i <= 1056; i++) begin
      tick();
      h = i % 1056;
      v = i / 1056;
      chk("line_hcount", 32'(hcount), 32'(h));
      chk("line_vcount", 32'(vcount), 32'(v));
      chk("line_hblnk", 32'(hblnk), (h >= 800) ? 1 : 0);
      chk("line_hsync", 32'(hsync), (h >= 840 && h <= 967) ? 1 : 0);
      chk("line_vblnk", 32'(vblnk), 0);
      chk("line_fs", 32'(frame_start), 0);
      if (hsync) hs_cnt++;
      if (hblnk) hb_cnt++;
    end
    chk("hsync_width", 32'(hs_cnt), 128);
    chk("hblnk_width", 32'(hb_cnt), 256);
    chk("hold_b_hcount", 32'(s_hcount), 0);
    chk("hold_b_fs", 32'(s_frame_start), 0);

    // Run to hcount 839 on line 1, then stall for five cycles.
    repeat (839) tick();
    chk("pre_stall_hcount", 32'(hcount), 839);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hcount", 32'(hcount), 839);
      chk("stall_vcount", 32'(vcount), 1);
      chk("stall_hsync", 32'(hsync), 0);
      chk("stall_hblnk", 32'(hblnk), 1);
    end
    en_a = 1'b1;
    tick();
    chk("resume_hcount", 32'(hcount), 840);
    chk("resume_hsync", 32'(hsync), 1);

    // Asynchronous reset between edges clears everything immediately.
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("restart_hcount", 32'(hcount), 32'(i));
      chk("restart_vcount", 32'(vcount), 0);
    end
    en_a = 1'b0;

    // Full frame on the reduced raster: 12 * 7 = 84 cycles.
    en_b   = 1'b1;
    fs_cnt = 0;
    for (int i = 1; i <= 84; i++) begin
      tick();
      h = i % 12;
      v = (i / 12) % 7;
      chk("frm_hcount", 32'(s_hcount), 32'(h));
      chk("frm_vcount", 32'(s_vcount), 32'(v));
      chk("frm_hblnk", 32'(s_hblnk), (h >= 8) ? 1 : 0);
      chk("frm_hsync", 32'(s_hsync), (h == 9 || h == 10) ? 1 : 0);
      chk("frm_vblnk", 32'(s_vblnk), (v >= 4) ? 1 : 0);
      chk("frm_vsync", 32'(s_vsync), (v == 5) ? 1 : 0);
      chk("frm_fs", 32'(s_frame_start), (i == 84) ? 1 : 0);
      if (s_frame_start) fs_cnt++;
    end
    chk("frm_fs_count", 32'(fs_cnt), 1);

    // Stall exactly on the wrap cycle (11,6): no wrap, no pulse.
    repeat (83) tick();
    chk("prewrap_hcount", 32'(s_hcount), 11);
    chk("prewrap_vcount", 32'(s_vcount), 6);
    en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wrapstall_hcount", 32'(s_hcount), 11);
      chk("wrapstall_vcount", 32'(s_vcount), 6);
      chk("wrapstall_fs", 32'(s_frame_start), 0);
      chk("wrapstall_vsync", 32'(s_vsync), 0);
      chk("wrapstall_vblnk", 32'(s_vblnk), 1);
    end
    en_b = 1'b1;
    tick();
    chk("wrap_hcount", 32'(s_hcount), 0);
    chk("wrap_vcount", 32'(s_vcount), 0);
    chk("wrap_fs", 32'(s_frame_start), 1);
    chk("wrap_vblnk", 32'(s_vblnk), 0);
    en_b = 1'b0;
    tick();
    chk("held00_hcount", 32'(s_hcount), 0);
    chk("held00_fs", 32'(s_frame_start), 0);
    en_b = 1'b1;
    tick();
    chk("post_hcount", 32'(s_hcount), 1);
    chk("post_fs", 32'(s_frame_start), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
